// File: rtl/odd_seq_ctrl.sv
// odd_seq_ctrl: command-driven sequencer that streams odd values start..limit
// to a consumer over a valid/ready link, repeating the pass a programmable
// number of times, and reporting busy/done/err status.

module odd_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int RUNS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_start,
  input  logic [WIDTH-1:0]  cmd_limit,
  input  logic [RUNS_W-1:0] cmd_runs,
  input  logic              abort,
  output logic [WIDTH-1:0]  cnt_o,
  output logic              cnt_valid,
  input  logic              cnt_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [WIDTH-1:0]  start_q;
  logic [WIDTH-1:0]  limit_q;
  logic [RUNS_W-1:0] runs_q;
  logic [RUNS_W-1:0] pass_q;

  logic [WIDTH-1:0]  cap_start;
  logic              cap_bad;
  logic [WIDTH:0]    nxt;
  logic              last_pass;
  logic              transfer;

  // The first value is always odd; a command is rejected when its forced-odd
  // start is above the limit or it asks for zero passes.
  assign cap_start = cmd_start | WIDTH'(1);
  assign cap_bad   = (cap_start > cmd_limit) || (cmd_runs == '0);

  // The step is computed one bit wider so a limit at the top of the range
  // ends the pass instead of wrapping back to a small value.
  assign nxt       = {1'b0, cnt_o} + (WIDTH+1)'(2);
  assign last_pass = (pass_q == (runs_q - RUNS_W'(1)));
  assign transfer  = cnt_valid && cnt_ready;

  assign cmd_ready = (state == IDLE);

  // Sequencer state, captured command and all registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      start_q   <= '0;
      limit_q   <= '0;
      runs_q    <= '0;
      pass_q    <= '0;
      cnt_o     <= '0;
      cnt_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cnt_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              if (cap_bad) begin
                err <= 1'b1;
              end else begin
                start_q   <= cap_start;
                limit_q   <= cmd_limit;
                runs_q    <= cmd_runs;
                pass_q    <= '0;
                cnt_o     <= cap_start;
                cnt_valid <= 1'b1;
                busy      <= 1'b1;
                state     <= RUN;
              end
            end
          end
          RUN: begin
            if (transfer) begin
              if (nxt <= {1'b0, limit_q}) begin
                cnt_o <= nxt[WIDTH-1:0];
              end else if (!last_pass) begin
                pass_q <= pass_q + RUNS_W'(1);
                cnt_o  <= start_q;
              end else begin
                cnt_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= DONE;
              end
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_odd_seq_ctrl.sv
// Testbench for odd_seq_ctrl: table-driven commands, hand-written corner
// sequences (backpressure, abort, async reset) and randomized commands, all
// checked against a value-list model built directly from the command fields.

module tb_odd_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_start;
  logic [7:0] cmd_limit;
  logic [3:0] cmd_runs;
  logic       abort;
  logic [7:0] cnt_o;
  logic       cnt_valid;
  logic       cnt_ready;
  logic       busy;
  logic       done;
  logic       err;

  int assertions = 0;
  int failures   = 0;

  logic [7:0] model_q[$];

  typedef struct {
    logic [7:0] start;
    logic [7:0] limit;
    logic [3:0] runs;
    bit         exp_err;
    int         exp_beats;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[9];

  odd_seq_ctrl #(.WIDTH(8), .RUNS_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_limit (cmd_limit),
    .cmd_runs  (cmd_runs),
    .abort     (abort),
    .cnt_o     (cnt_o),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected output stream: every odd value from the forced-odd start up to
  // the limit, repeated once per pass; empty for a command that is rejected.
  task automatic buildModel(input logic [7:0] st, input logic [7:0] lim, input logic [3:0] rn);
    int s;
    s = int'(st) | 1;
    model_q.delete();
    if (s > int'(lim) || rn == 0) return;
    for (int p = 0; p < int'(rn); p++)
      for (int v = s; v <= int'(lim); v += 2)
        model_q.push_back(8'(v));
  endtask

  // Present one command for a single cycle; must be called at a falling edge
  // while the controller is idle. Returns at the falling edge after accept.
  task automatic applyStimulus(input logic [7:0] st, input logic [7:0] lim, input logic [3:0] rn);
    cmd_valid = 1'b1;
    cmd_start = st;
    cmd_limit = lim;
    cmd_runs  = rn;
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Observe the cycle after a rejected command and the one after that.
  task automatic checkReject(input logic [7:0] prev_cnt);
    checkOutput("reject_err", err, 1);
    checkOutput("reject_busy", busy, 0);
    checkOutput("reject_valid", cnt_valid, 0);
    checkOutput("reject_cmd_ready", cmd_ready, 1);
    checkOutput("reject_cnt_kept", cnt_o, prev_cnt);
    @(negedge clk);
    checkOutput("reject_err_pulse", err, 0);
    checkOutput("reject_cmd_ready2", cmd_ready, 1);
  endtask

  // Drain a running sequence, checking each delivered beat against the
  // model, value holding under backpressure and the done pulse at the end.
  task automatic runStream(input bit rnd, output int beats, output int cycles,
                           output logic [7:0] last);
    bit         finished;
    bit         stalled;
    logic [7:0] held;
    beats    = 0;
    cycles   = 0;
    last     = '0;
    finished = 1'b0;
    stalled  = 1'b0;
    held     = '0;
    while (!finished && cycles < 3000) begin
      cnt_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_start = 8'($urandom_range(0, 255));
        cmd_limit = 8'($urandom_range(0, 255));
        cmd_runs  = 4'($urandom_range(0, 15));
      end
      if (done) begin
        finished = 1'b1;
      end else begin
        if (stalled) begin
          checkOutput("hold_value", cnt_o, held);
          checkOutput("hold_valid", cnt_valid, 1);
        end
        checkOutput("run_err_quiet", err, 0);
        checkOutput("run_cmd_ready", cmd_ready, 0);
        checkOutput("run_busy", busy, cnt_valid);
        if (cnt_valid && cnt_ready) begin
          checkOutput("beat_expected", model_q.size() > 0, 1);
          if (model_q.size() > 0) checkOutput("beat_value", cnt_o, model_q.pop_front());
          beats++;
          last = cnt_o;
        end
        stalled = cnt_valid && !cnt_ready;
        held    = cnt_o;
        @(negedge clk);
        cycles++;
      end
    end
    checkOutput("stream_finished", finished, 1);
    cmd_valid = 1'b0;
    if (finished) begin
      checkOutput("done_valid_low", cnt_valid, 0);
      checkOutput("done_busy_low", busy, 0);
      checkOutput("done_cmd_ready", cmd_ready, 0);
      checkOutput("done_all_sent", model_q.size(), 0);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      checkOutput("idle_cmd_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    int         beats;
    int         cycles;
    logic [7:0] last;
    logic [7:0] prev;

    vecs[0] = '{8'd3,   8'd9,   4'd1,  1'b0, 4,  8'd3,   8'd9};
    vecs[1] = '{8'd4,   8'd5,   4'd3,  1'b0, 3,  8'd5,   8'd5};
    vecs[2] = '{8'd253, 8'd255, 4'd2,  1'b0, 4,  8'd253, 8'd255};
    vecs[3] = '{8'd9,   8'd3,   4'd1,  1'b1, 0,  8'd0,   8'd0};
    vecs[4] = '{8'd3,   8'd9,   4'd0,  1'b1, 0,  8'd0,   8'd0};
    vecs[5] = '{8'd1,   8'd1,   4'd15, 1'b0, 15, 8'd1,   8'd1};
    vecs[6] = '{8'd8,   8'd8,   4'd1,  1'b1, 0,  8'd0,   8'd0};
    vecs[7] = '{8'd255, 8'd255, 4'd1,  1'b0, 1,  8'd255, 8'd255};
    vecs[8] = '{8'd0,   8'd6,   4'd2,  1'b0, 6,  8'd1,   8'd5};

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_limit = '0;
    cmd_runs  = '0;
    abort     = 1'b0;
    cnt_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_cnt_o", cnt_o, 0);
    checkOutput("rst_cnt_valid", cnt_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven commands at full throughput
    for (int i = 0; i < 9; i++) begin
      buildModel(vecs[i].start, vecs[i].limit, vecs[i].runs);
      prev = cnt_o;
      applyStimulus(vecs[i].start, vecs[i].limit, vecs[i].runs);
      if (vecs[i].exp_err) begin
        checkReject(prev);
      end else begin
        checkOutput("first_value", cnt_o, vecs[i].exp_first);
        checkOutput("first_valid", cnt_valid, 1);
        checkOutput("first_busy", busy, 1);
        runStream(1'b0, beats, cycles, last);
        checkOutput("vec_beats", beats, vecs[i].exp_beats);
        checkOutput("vec_last", last, vecs[i].exp_last);
        checkOutput("vec_throughput", cycles, vecs[i].exp_beats);
      end
    end

    // Backpressure: consumer stalls for three cycles while 3 is presented
    buildModel(8'd1, 8'd7, 4'd1);
    applyStimulus(8'd1, 8'd7, 4'd1);
    cnt_ready = 1'b1;
    checkOutput("bp_first", cnt_o, 1);
    void'(model_q.pop_front());
    @(negedge clk);
    checkOutput("bp_second", cnt_o, 3);
    cnt_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_hold_value", cnt_o, 3);
      checkOutput("bp_hold_valid", cnt_valid, 1);
    end
    runStream(1'b0, beats, cycles, last);
    checkOutput("bp_beats", beats, 3);
    checkOutput("bp_last", last, 7);

    // Abort mid-run while 5 is presented
    applyStimulus(8'd1, 8'd15, 4'd1);
    cnt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_at_value", cnt_o, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_valid", cnt_valid, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    checkOutput("abort_no_late_done", done, 0);

    // Abort wins over a same-cycle accept, legal or not
    cmd_valid = 1'b1; cmd_start = 8'd3; cmd_limit = 8'd9; cmd_runs = 4'd1;
    abort     = 1'b1;
    @(negedge clk);
    cmd_start = 8'd9; cmd_limit = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    checkOutput("abort_cmd_valid", cnt_valid, 0);
    checkOutput("abort_cmd_busy", busy, 0);
    checkOutput("abort_cmd_err", err, 0);
    checkOutput("abort_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    checkOutput("abort_cmd_dropped", cnt_valid, 0);

    // Randomized commands with random backpressure
    for (int n = 0; n < 25; n++) begin
      int st, lim, rn, kind;
      st   = int'($urandom_range(0, 255));
      kind = int'($urandom_range(0, 7));
      lim  = st + int'($urandom_range(0, 24));
      if (lim > 255) lim = 255;
      rn   = int'($urandom_range(1, 3));
      if (kind == 0) rn = 0;
      if (kind == 1 && st > 1) lim = int'($urandom_range(0, (st | 1) - 1));
      if (kind == 2) begin
        st  = int'($urandom_range(240, 255));
        lim = 255;
      end
      buildModel(8'(st), 8'(lim), 4'(rn));
      prev = cnt_o;
      applyStimulus(8'(st), 8'(lim), 4'(rn));
      if (model_q.size() == 0) checkReject(prev);
      else runStream(1'b1, beats, cycles, last);
    end

    // Asynchronous reset in the middle of a run
    cnt_ready = 1'b1;
    applyStimulus(8'd1, 8'd31, 4'd2);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_cnt_o", cnt_o, 0);
    checkOutput("arst_valid", cnt_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("arst_no_done", done, 0);
    checkOutput("arst_idle_valid", cnt_valid, 0);

    // Normal operation resumes after the reset
    buildModel(8'd3, 8'd9, 4'd1);
    applyStimulus(8'd3, 8'd9, 4'd1);
    runStream(1'b0, beats, cycles, last);
    checkOutput("post_rst_beats", beats, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
